// File: rtl/seq101_frame_tx_pkg.sv
// Shared definitions for the "101" framed serial link: state encodings, preamble,
// and a counter-width helper used by both the transmitter and its bit-tick generator.
package seq101_frame_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PRE  = 2'b01,
      ST_DATA = 2'b10,
      ST_GAP  = 2'b11
   } state_e;

   localparam logic [2:0] PREAMBLE = 3'b101;
   localparam int         PRE_LEN  = 3;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq101_frame_tx_bit_tick_gen.sv
// Bit-period counter: tick marks the last clk cycle of each serial bit.
// tick_nxt is the same condition one cycle ahead, for registered end-of-frame flags.
module bit_tick_gen
   import seq101_frame_tx_pkg::*;
#(
   parameter int BIT_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick,
   output logic tick_nxt
);

   localparam int               CNT_W    = cnt_width(BIT_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Counter parks at zero whenever disabled so every frame starts on a fresh period.
   always_comb begin
      cnt_d = '0;
      if (!clear && enable && (cnt_q != CNT_LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick     = (cnt_q == CNT_LAST);
   assign tick_nxt = (cnt_d == CNT_LAST);

endmodule

// File: rtl/seq101_frame_tx.sv
// Serial frame transmitter: preamble 101, WIDTH data bits MSB-first, GAP_BITS zeros.
// Outputs other than din_ready are registered from the next-state values.
module seq101_frame_tx
   import seq101_frame_tx_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int BIT_DIV  = 1,
   parameter int GAP_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din_data,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int MAX_LEN = (WIDTH > PRE_LEN) ?
                            ((WIDTH > GAP_BITS) ? WIDTH : GAP_BITS) :
                            ((PRE_LEN > GAP_BITS) ? PRE_LEN : GAP_BITS);
   localparam int IDX_W = cnt_width(MAX_LEN - 1);

   localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [1:0]       PRE_TOP   = 2'(PRE_LEN - 1);
   localparam bit               GAP_EN    = (GAP_BITS > 0);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;

   logic handshake;
   logic tick;
   logic tick_nxt;
   logic last_bit_d;

   assign din_ready = (state_q == ST_IDLE) & ~reset;
   assign handshake = din_valid & din_ready;

   bit_tick_gen #(
      .BIT_DIV (BIT_DIV)
   ) u_tick (
      .clk      (clk),
      .reset    (reset),
      .clear    (handshake),
      .enable   (state_q != ST_IDLE),
      .tick     (tick),
      .tick_nxt (tick_nxt)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               state_d = ST_PRE;
               idx_d   = '0;
               shift_d = din_data;
            end
         end
         ST_PRE: begin
            if (tick) begin
               if (idx_q == PRE_LAST) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q << 1;
               if (idx_q == DATA_LAST) begin
                  state_d = GAP_EN ? ST_GAP : ST_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (idx_q == GAP_LAST) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the registered state.
   always_comb begin
      dout_d = 1'b0;
      case (state_d)
         ST_PRE:  dout_d = PREAMBLE[PRE_TOP - idx_d[1:0]];
         ST_DATA: dout_d = shift_d[WIDTH-1];
         default: dout_d = 1'b0;
      endcase
      dout_valid_d = (state_d == ST_PRE) || (state_d == ST_DATA);
      busy_d       = (state_d != ST_IDLE);
      last_bit_d   = ((state_d == ST_DATA) && (idx_d == DATA_LAST) && !GAP_EN) ||
                     ((state_d == ST_GAP) && (idx_d == GAP_LAST));
      frame_done_d = last_bit_d && tick_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         shift_q      <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq101_frame_tx.sv
// Directed bench for seq101_frame_tx: three parameterisations share clk and reset.
// Output vectors are {dout, dout_valid, busy, frame_done, din_ready}.
module tb_seq101_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic       a_valid, b_valid, c_valid;
   logic [7:0] a_data, b_data, c_data;
   logic       a_ready, a_dout, a_dv, a_busy, a_done;
   logic       b_ready, b_dout, b_dv, b_busy, b_done;
   logic       c_ready, c_dout, c_dv, c_busy, c_done;

   int total = 0;
   int bad   = 0;

   seq101_frame_tx #(.WIDTH(8), .BIT_DIV(1), .GAP_BITS(2)) u_dut_a (
      .clk(clk), .reset(reset), .din_valid(a_valid), .din_data(a_data),
      .din_ready(a_ready), .dout(a_dout), .dout_valid(a_dv), .busy(a_busy),
      .frame_done(a_done)
   );

   seq101_frame_tx #(.WIDTH(8), .BIT_DIV(3), .GAP_BITS(2)) u_dut_b (
      .clk(clk), .reset(reset), .din_valid(b_valid), .din_data(b_data),
      .din_ready(b_ready), .dout(b_dout), .dout_valid(b_dv), .busy(b_busy),
      .frame_done(b_done)
   );

   seq101_frame_tx #(.WIDTH(8), .BIT_DIV(1), .GAP_BITS(0)) u_dut_c (
      .clk(clk), .reset(reset), .din_valid(c_valid), .din_data(c_data),
      .din_ready(c_ready), .dout(c_dout), .dout_valid(c_dv), .busy(c_busy),
      .frame_done(c_done)
   );

   // Expected vector i cycles after the accept edge (frame occupies cycles 1..F).
   function automatic logic [4:0] exp_vec(input int i, input int bd, input int g,
                                          input logic [7:0] w);
      int   f;
      int   n;
      logic b;
      f = (11 + g) * bd;
      if (i < 1 || i > f) return 5'b00001;
      n = (i - 1) / bd;
      if (n < 3)       b = (n != 1);
      else if (n < 11) b = w[10 - n];
      else             b = 1'b0;
      return {b, (n < 11), 1'b1, (i == f), 1'b0};
   endfunction

   task automatic test_reset();
      logic [4:0] got;
      reset   = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
      a_data  = 8'hFF; b_data = 8'hFF; c_data = 8'hFF;
      repeat (2) @(negedge clk);
      got = {a_dout, a_dv, a_busy, a_done, a_ready};
      total++;
      if (got !== 5'b00000) begin
         bad++; $display("FAIL reset_a got=%b exp=%b", got, 5'b00000);
      end
      got = {b_dout, b_dv, b_busy, b_done, b_ready};
      total++;
      if (got !== 5'b00000) begin
         bad++; $display("FAIL reset_b got=%b exp=%b", got, 5'b00000);
      end
      got = {c_dout, c_dv, c_busy, c_done, c_ready};
      total++;
      if (got !== 5'b00000) begin
         bad++; $display("FAIL reset_c got=%b exp=%b", got, 5'b00000);
      end
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      got = {a_ready, b_ready, c_ready, a_busy, b_busy};
      total++;
      if (got !== 5'b11100) begin
         bad++; $display("FAIL reset_release got=%b exp=%b", got, 5'b11100);
      end
   endtask

   task automatic test_basic();
      logic [4:0] got;
      logic [4:0] exp;
      a_valid = 1'b1; a_data = 8'hA5;
      total++;
      if (a_ready !== 1'b1) begin
         bad++; $display("FAIL basic_accept got=%b exp=1", a_ready);
      end
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         a_valid = 1'b0;
         a_data  = 8'h00;
         got = {a_dout, a_dv, a_busy, a_done, a_ready};
         exp = exp_vec(i, 1, 2, 8'hA5);
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_slow_bits();
      logic [4:0] got;
      logic [4:0] exp;
      int dv_cnt;
      dv_cnt  = 0;
      b_valid = 1'b1; b_data = 8'h80;
      total++;
      if (b_ready !== 1'b1) begin
         bad++; $display("FAIL slow_accept got=%b exp=1", b_ready);
      end
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         b_valid = 1'b0;
         got = {b_dout, b_dv, b_busy, b_done, b_ready};
         exp = exp_vec(i, 3, 2, 8'h80);
         if (b_dv === 1'b1) dv_cnt++;
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL slow cyc=%0d got=%b exp=%b", i, got, exp);
         end
      end
      total++;
      if (dv_cnt != 33) begin
         bad++; $display("FAIL slow_dv_count got=%0d exp=33", dv_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] got;
      logic [4:0] exp;
      int done_cnt;
      done_cnt = 0;
      c_valid  = 1'b1; c_data = 8'hFF;
      total++;
      if (c_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_accept got=%b exp=1", c_ready);
      end
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (i == 1)  c_data  = 8'h00;
         if (i == 13) c_valid = 1'b0;
         got = {c_dout, c_dv, c_busy, c_done, c_ready};
         exp = (i <= 12) ? exp_vec(i, 1, 0, 8'hFF) : exp_vec(i - 12, 1, 0, 8'h00);
         if (c_done === 1'b1) done_cnt++;
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, got, exp);
         end
      end
      total++;
      if (done_cnt != 2) begin
         bad++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt);
      end
   endtask

   task automatic test_reset_abort();
      logic [4:0] got;
      logic [4:0] exp;
      a_valid = 1'b1; a_data = 8'hFF;
      total++;
      if (a_ready !== 1'b1) begin
         bad++; $display("FAIL abort_accept got=%b exp=1", a_ready);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         a_valid = 1'b0;
         got = {a_dout, a_dv, a_busy, a_done, a_ready};
         exp = exp_vec(i, 1, 2, 8'hFF);
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL abort_pre cyc=%0d got=%b exp=%b", i, got, exp);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      got = {a_dout, a_dv, a_busy, a_done, a_ready};
      total++;
      if (got !== 5'b00000) begin
         bad++; $display("FAIL abort_reset got=%b exp=%b", got, 5'b00000);
      end
      reset = 1'b0;
      @(negedge clk);
      got = {a_dout, a_dv, a_busy, a_done, a_ready};
      total++;
      if (got !== 5'b00001) begin
         bad++; $display("FAIL abort_idle got=%b exp=%b", got, 5'b00001);
      end
      a_valid = 1'b1; a_data = 8'h01;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         a_valid = 1'b0;
         got = {a_dout, a_dv, a_busy, a_done, a_ready};
         exp = exp_vec(i, 1, 2, 8'h01);
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL abort_resend cyc=%0d got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_loopback();
      logic [7:0] w;
      logic       ok;
      logic [1:0] det_st;
      int         det_cnt;
      int         det_cyc;
      det_st = 2'd0;
      for (int f = 0; f < 16; f++) begin
         // Data must be free of 101 and must not start with 01 (would alias after the preamble).
         ok = 1'b0;
         w  = 8'h00;
         while (!ok) begin
            w  = 8'($urandom_range(0, 255));
            ok = (w[7:6] != 2'b01);
            for (int j = 0; j <= 5; j++) begin
               if (w[j +: 3] == 3'b101) ok = 1'b0;
            end
         end
         a_valid = 1'b1; a_data = w;
         total++;
         if (a_ready !== 1'b1) begin
            bad++; $display("FAIL loop_accept frame=%0d got=%b exp=1", f, a_ready);
         end
         det_cnt = 0;
         det_cyc = -1;
         for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            a_valid = 1'b0;
            if (det_st == 2'd2 && a_dout === 1'b1) begin
               det_cnt++;
               det_cyc = i;
            end
            case (det_st)
               2'd0:    det_st = a_dout ? 2'd1 : 2'd0;
               2'd1:    det_st = a_dout ? 2'd1 : 2'd2;
               default: det_st = a_dout ? 2'd1 : 2'd0;
            endcase
         end
         total++;
         if (det_cnt != 1 || det_cyc != 3) begin
            bad++;
            $display("FAIL loopback frame=%0d word=%h got=%0d@%0d exp=1@3", f, w, det_cnt, det_cyc);
         end
      end
   endtask

   task automatic test_hold_data();
      logic [4:0] got;
      logic [4:0] exp;
      a_valid = 1'b1; a_data = 8'h3C;
      total++;
      if (a_ready !== 1'b1) begin
         bad++; $display("FAIL hold_accept got=%b exp=1", a_ready);
      end
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         a_valid = (i < 13) ? ((i % 2) == 1) : 1'b0;
         a_data  = 8'($urandom);
         got = {a_dout, a_dv, a_busy, a_done, a_ready};
         exp = exp_vec(i, 1, 2, 8'h3C);
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL hold cyc=%0d got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow_bits();
      test_back_to_back();
      test_reset_abort();
      test_loopback();
      test_hold_data();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
